jam_param: RTL and testbench

- Parametrised job-assignment engine. It is the successor to the fixed 8x8 JAM and exhaustively enumerates all N! worker-to-job permutations.
- For each permutation it fetches N costs from an external cost ROM with 1-cycle read latency, sums them, and tracks the best total and how many permutations reach it.
- Adds over JAM: generic N, cost, sum and count widths; a min/max mode; a START/BUSY handshake for re-runs; and count saturation.

---
 rtl/jam_pkg.sv | 28 ++
 rtl/jam_next_perm.sv | 50 +++++
 rtl/jam_param.sv | 177 +++++++++++++++++
 tb/tb_jam_param.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and helpers for the parametrised job-assignment engine.
package jam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACC,
        ST_UPDATE,
        ST_DONE
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int unsigned fact(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 2; i <= n; i++) begin
            r = r * i;
        end
        return r;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of an N-element permutation.
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0][IDX_W-1:0] perm_i,
    output logic [N-1:0][IDX_W-1:0] next_o,
    output logic                    is_last_o
);

    function automatic logic [IDX_W-1:0] ix(input int unsigned v);
        return v[IDX_W-1:0];
    endfunction

    logic                    found;
    int unsigned             pivot;
    int unsigned             succ;
    logic [N-1:0][IDX_W-1:0] swapped;

    always_comb begin
        found   = 1'b0;
        pivot   = 0;
        succ    = 0;
        // Scan right to left for the first ascent; its left element is the pivot.
        for (int unsigned k = 0; k < N - 1; k++) begin
            if (!found && (perm_i[ix(N - 2 - k)] < perm_i[ix(N - 1 - k)])) begin
                found = 1'b1;
                pivot = N - 2 - k;
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            if ((k > pivot) && (perm_i[ix(k)] > perm_i[ix(pivot)])) begin
                succ = k;
            end
        end
        swapped              = perm_i;
        swapped[ix(pivot)]   = perm_i[ix(succ)];
        swapped[ix(succ)]    = perm_i[ix(pivot)];
        next_o               = swapped;
        for (int unsigned k = 0; k < N; k++) begin
            if (k > pivot) begin
                next_o[ix(k)] = swapped[ix(N + pivot - k)];
            end
        end
        is_last_o = !found;
    end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N! job-assignment search: fetches N costs per permutation from a
// 1-cycle-latency ROM and tracks the best total and how many permutations hit it.
module jam_param
    import jam_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned COST_W     = 7,
    parameter int unsigned SUM_W      = 10,
    parameter int unsigned CNT_W      = 16,
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned IDX_W      = idx_w(N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              MODE,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic              BUSY,
    output logic              Valid,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount
);

    function automatic logic [IDX_W-1:0] ix(input int unsigned v);
        return v[IDX_W-1:0];
    endfunction

    function automatic logic [N-1:0][IDX_W-1:0] ident();
        logic [N-1:0][IDX_W-1:0] r;
        for (int unsigned k = 0; k < N; k++) begin
            r[ix(k)] = ix(k);
        end
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N-1:0][IDX_W-1:0] perm_q, perm_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [SUM_W-1:0]        best_q, best_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    first_q, first_d;
    logic                    mode_q, mode_d;
    logic                    auto_q, auto_d;
    logic [IDX_W-1:0]        w_q, w_d;
    logic [IDX_W-1:0]        j_q, j_d;

    logic [N-1:0][IDX_W-1:0] perm_next;
    logic                    perm_last;
    logic [IDX_W-1:0]        nidx;
    logic [SUM_W-1:0]        cost_x;
    logic                    start_ok;
    logic                    better;

    jam_next_perm #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_next_perm (
        .perm_i    (perm_q),
        .next_o    (perm_next),
        .is_last_o (perm_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            perm_q  <= ident();
            sum_q   <= '0;
            best_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            mode_q  <= MODE_MIN;
            auto_q  <= AUTO_START;
            w_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            perm_q  <= perm_d;
            sum_q   <= sum_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            mode_q  <= mode_d;
            auto_q  <= auto_d;
            w_q     <= w_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        perm_d   = perm_q;
        sum_d    = sum_q;
        best_d   = best_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        mode_d   = mode_q;
        auto_d   = 1'b0;
        w_d      = w_q;
        j_d      = j_q;
        nidx     = idx_q + 1'b1;
        cost_x   = SUM_W'(Cost);
        start_ok = START | auto_q;
        better   = (mode_q == MODE_MAX) ? (sum_q > best_q) : (sum_q < best_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    mode_d  = MODE;
                    perm_d  = ident();
                    first_d = 1'b1;
                    best_d  = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                    w_d     = '0;
                    j_d     = '0;
                    state_d = ST_FETCH;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Cost arriving now belongs to the previous index, so slot 0 adds nothing.
                if (idx_q != '0) begin
                    sum_d = sum_q + cost_x;
                end
                if (idx_q == ix(N - 1)) begin
                    state_d = ST_ACC;
                end else begin
                    idx_d = nidx;
                    w_d   = nidx;
                    j_d   = perm_q[nidx];
                end
            end
            ST_ACC: begin
                sum_d   = sum_q + cost_x;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (first_q || better) begin
                    best_d  = sum_q;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    first_d = 1'b0;
                end else if (sum_q == best_q) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (perm_last) begin
                    state_d = ST_DONE;
                end else begin
                    perm_d  = perm_next;
                    idx_d   = '0;
                    sum_d   = '0;
                    w_d     = '0;
                    j_d     = perm_next[0];
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign W          = w_q;
    assign J          = j_q;
    assign BUSY       = (state_q == ST_FETCH) || (state_q == ST_ACC) || (state_q == ST_UPDATE);
    assign Valid      = (state_q == ST_DONE);
    assign MinCost    = best_q;
    assign MatchCount = cnt_q;

endmodule

// File: tb/tb_jam_param.sv
// Directed bench for jam_param: several parameterisations, each with its own cost ROM model.
`timescale 1ns/1ps
module tb_jam_param;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic       clk = 1'b0;
  logic [4:0] rst_v   = '1;
  logic [4:0] start_v = '0;
  logic [4:0] mode_v  = '0;
  logic [4:0] valid_v;
  logic [4:0] busy_v;
  logic       sel_a = 1'b0;

  always #5 clk = ~clk;

  // A: N=5, auto start, diagonal-zero costs or all 5
  logic [2:0] w_a, j_a;  logic [6:0] cost_a;  logic [9:0] min_a;  logic [15:0] cnt_a;
  // C: N=3, cost (W+1)*(J+1)
  logic [1:0] w_c, j_c;  logic [6:0] cost_c;  logic [9:0] min_c;  logic [15:0] cnt_c;
  // D: N=6, CNT_W=8, all costs 9
  logic [2:0] w_d, j_d;  logic [6:0] cost_d;  logic [9:0] min_d;  logic [7:0]  cnt_d;
  // E: N=4, diagonal 1, elsewhere 3
  logic [1:0] w_e, j_e;  logic [6:0] cost_e;  logic [9:0] min_e;  logic [15:0] cnt_e;
  // F: N=2, all costs 4
  logic       w_f, j_f;  logic [6:0] cost_f;  logic [9:0] min_f;  logic [15:0] cnt_f;

  logic va, vc, vd, ve, vf, ba, bc, bd, be, bf;
  assign valid_v = {vf, ve, vd, vc, va};
  assign busy_v  = {bf, be, bd, bc, ba};

  always @(posedge clk) begin
    cost_a <= sel_a ? 7'd5 : ((w_a == j_a) ? 7'd0 : 7'd100);
    cost_c <= 7'((int'(w_c) + 1) * (int'(j_c) + 1));
    cost_d <= 7'd9;
    cost_e <= (w_e == j_e) ? 7'd1 : 7'd3;
    cost_f <= 7'd4;
  end

  jam_param #(.N(5), .AUTO_START(1'b1)) u_a (
    .CLK(clk), .RST(rst_v[0]), .START(start_v[0]), .MODE(mode_v[0]), .W(w_a), .J(j_a),
    .Cost(cost_a), .BUSY(ba), .Valid(va), .MinCost(min_a), .MatchCount(cnt_a));
  jam_param #(.N(3), .AUTO_START(1'b0)) u_c (
    .CLK(clk), .RST(rst_v[1]), .START(start_v[1]), .MODE(mode_v[1]), .W(w_c), .J(j_c),
    .Cost(cost_c), .BUSY(bc), .Valid(vc), .MinCost(min_c), .MatchCount(cnt_c));
  jam_param #(.N(6), .CNT_W(8), .AUTO_START(1'b0)) u_d (
    .CLK(clk), .RST(rst_v[2]), .START(start_v[2]), .MODE(mode_v[2]), .W(w_d), .J(j_d),
    .Cost(cost_d), .BUSY(bd), .Valid(vd), .MinCost(min_d), .MatchCount(cnt_d));
  jam_param #(.N(4), .AUTO_START(1'b0)) u_e (
    .CLK(clk), .RST(rst_v[3]), .START(start_v[3]), .MODE(mode_v[3]), .W(w_e), .J(j_e),
    .Cost(cost_e), .BUSY(be), .Valid(ve), .MinCost(min_e), .MatchCount(cnt_e));
  jam_param #(.N(2), .AUTO_START(1'b0)) u_f (
    .CLK(clk), .RST(rst_v[4]), .START(start_v[4]), .MODE(mode_v[4]), .W(w_f), .J(j_f),
    .Cost(cost_f), .BUSY(bf), .Valid(vf), .MinCost(min_f), .MatchCount(cnt_f));

  // Edges are counted from the moment the request is presented; edge 1 samples it.
  task automatic run(input int unsigned k, input bit do_start, input int unsigned limit,
                     output int unsigned edges);
    edges = 0;
    if (do_start) start_v[k] = 1'b1;
    do begin
      @(posedge clk); #1;
      edges++;
      start_v[k] = 1'b0;
      if (edges == 1) chk("busy_after_start", busy_v[k], 1'b1);
    end while (!valid_v[k] && edges < limit);
    chk("busy_at_valid", busy_v[k], 1'b0);
  endtask

  task automatic pulse_end(input int unsigned k);
    @(posedge clk); #1;
    chk("valid_single_cycle", valid_v[k], 1'b0);
  endtask

  initial begin
    int unsigned e;

    #12;
    chk("rst_W", w_a, 3'd0);
    chk("rst_J", j_a, 3'd0);
    chk("rst_busy", ba, 1'b0);
    chk("rst_valid", va, 1'b0);
    chk("rst_min", min_a, 10'd0);
    chk("rst_cnt", cnt_a, 16'd0);

    @(posedge clk); #1;
    rst_v = '0;
    run(0, 1'b0, 2000, e);
    chk("a_auto_valid_edges", e, 841);
    chk("a_diag_min", min_a, 10'd0);
    chk("a_diag_cnt", cnt_a, 16'd1);
    pulse_end(0);
    chk("a_hold_min", min_a, 10'd0);

    sel_a = 1'b1;
    run(0, 1'b1, 2000, e);
    chk("a_flat_valid_edges", e, 841);
    chk("a_flat_min", min_a, 10'd25);
    chk("a_flat_cnt", cnt_a, 16'd120);

    mode_v[1] = 1'b0;
    run(1, 1'b1, 100, e);
    chk("c_min_valid_edges", e, 31);
    chk("c_min", min_c, 10'd10);
    chk("c_min_cnt", cnt_c, 16'd1);
    pulse_end(1);
    mode_v[1] = 1'b1;
    run(1, 1'b1, 100, e);
    chk("c_max_valid_edges", e, 31);
    chk("c_max", min_c, 10'd14);
    chk("c_max_cnt", cnt_c, 16'd1);
    mode_v[1] = 1'b0;

    run(2, 1'b1, 7000, e);
    chk("d_valid_edges", e, 5761);
    chk("d_min", min_d, 10'd54);
    chk("d_cnt_saturated", cnt_d, 8'd255);

    start_v[3] = 1'b1;
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
      start_v[3] = (e == 20);
    end while (!ve && e < 400);
    chk("e_start_while_busy_edges", e, 145);
    chk("e_min", min_e, 10'd4);
    chk("e_cnt", cnt_e, 16'd1);
    pulse_end(3);

    start_v[3] = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      start_v[3] = 1'b0;
    end
    chk("e_pre_rst_W", w_e, 2'd2);
    chk("e_pre_rst_J", j_e, 2'd3);
    chk("e_pre_rst_min", min_e, 10'd4);
    rst_v[3] = 1'b1;
    #1;
    chk("e_rst_W", w_e, 2'd0);
    chk("e_rst_J", j_e, 2'd0);
    chk("e_rst_busy", be, 1'b0);
    chk("e_rst_valid", ve, 1'b0);
    chk("e_rst_min", min_e, 10'd0);
    chk("e_rst_cnt", cnt_e, 16'd0);
    @(posedge clk); #1;
    rst_v[3] = 1'b0;
    run(3, 1'b1, 400, e);
    chk("e_rerun_edges", e, 145);
    chk("e_rerun_min", min_e, 10'd4);
    chk("e_rerun_cnt", cnt_e, 16'd1);
    mode_v[3] = 1'b1;
    run(3, 1'b1, 400, e);
    chk("e_max_edges", e, 145);
    chk("e_max", min_e, 10'd12);
    chk("e_max_cnt", cnt_e, 16'd9);

    run(4, 1'b1, 50, e);
    chk("f_valid_edges", e, 9);
    chk("f_min", min_f, 10'd8);
    chk("f_cnt_tie", cnt_f, 16'd2);
    pulse_end(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
